mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, n_rst.
REQ-002 SHALL have parameter WAIT_W, default 4, memory-wait counter width.
REQ-003 SHALL have parameter TIMEOUT_EN, default 1; 1 enables memory-timeout halting.
REQ-004 SHALL have parameter RETIRE_W, default 16, retired-instruction counter width.
REQ-005 SHALL have ports:
- clk  in  1  clock
- n_rst  in  1  async active-low reset
- instr  in  32  current instruction register contents
- ihit  in  1  instruction memory ready
- dhit  in  1  data memory ready
- zero  in  1  ALU zero flag
- iren / dren / dwen  out  1 each  memory strobes
- ir_wen / pc_wen / reg_wen  out  1 each  register enables
- pc_src  out  2  0=PC+4, 1=branch, 2=jump, 3=register
- reg_dst  out  2  0=rd, 1=rt, 2=r31
- alu_src  out  1  0=rt, 1=imm16
- alu_ctr  out  4  cpu_types_pkg aluop_t
- ext_op / upper / mem_to_reg  out  1 each  datapath selects
- imm16  out  16  instr[15:0], or {11'b0, shamt} for SLL/SRL
- state  out  4  current FSM state code
- halt / mem_timeout / illegal_op  out  1 each  sticky status
- retired  out  RETIRE_W  retired-instruction count

Function
REQ-006 SHALL be a multicycle FSM; state codes: FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, BRANCH=6, JUMP=7, HALT=8.
REQ-007 FETCH SHALL assert iren; on ihit, assert ir_wen and pc_wen (pc_src=0) for that cycle and go to DECODE; otherwise stay.
REQ-008 DECODE SHALL last one cycle and route on the cpu_types_pkg opcode:
- J, JAL, RTYPE/JR -> JUMP
- BEQ, BNE -> BRANCH
- HALT -> HALT
- LW, SW, LUI, ALU-immediate, other RTYPE -> EXEC
- any other opcode or RTYPE funct -> FETCH, set illegal_op, not retired
REQ-009 EXEC SHALL last one cycle with the ALU decoded:
- SLL, SRL, ADD(U), SUB(U), AND, OR, XOR, NOR, SLT, SLTU per funct
- immediates: ADD, SLT, AND, OR, XOR
- LUI, LW, SW -> ALU_ADD
- alu_src=0 only for non-shift RTYPE
- next state: LW -> MEMRD, SW -> MEMWR, else WB
REQ-010 ext_op SHALL be 1 for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE; upper SHALL be 1 for LUI; LUI SHALL use Rs=0 externally.
REQ-011 MEMRD SHALL assert dren until dhit, then go to WB with mem_to_reg=1 held through WB.
REQ-012 MEMWR SHALL assert dwen until dhit, then go to FETCH and retire.
REQ-013 WB SHALL assert reg_wen for exactly one cycle (reg_dst=0 RTYPE, 1 otherwise), then go to FETCH and retire.
REQ-014 BRANCH SHALL drive alu_ctr=ALU_SUB with pc_src=1, and pc_wen=(BEQ&zero)|(BNE&~zero); it then goes to FETCH and retires.
REQ-015 JUMP SHALL assert pc_wen with pc_src=3 for JR, else 2; for JAL it SHALL also assert reg_wen with reg_dst=2; it then goes to FETCH and retires.
REQ-016 iren, dren, dwen SHALL be mutually exclusive; all strobes and enables SHALL be 0 outside their named states.
REQ-017 Wait counter SHALL:
- clear on entry to FETCH, MEMRD, MEMWR
- increment each cycle the awaited hit is low
- when it reaches 2^WAIT_W-1 with TIMEOUT_EN=1: set mem_timeout, go to HALT
- with TIMEOUT_EN=0: never time out
REQ-018 A hit arriving in the same cycle as the counter reaching terminal count SHALL take priority over the timeout.
REQ-019 HALT SHALL assert halt and hold all enables at 0 until reset.
REQ-020 retired SHALL increment by 1 per retirement and wrap modulo 2^RETIRE_W.
REQ-021 halt, mem_timeout, illegal_op SHALL be sticky until reset.

Reset
REQ-022 n_rst low SHALL immediately force: state=FETCH, all outputs 0, wait counter 0, retired 0, sticky flags 0, including mid-transaction.
REQ-023 After reset release, iren SHALL assert on the first clk edge.

Verification
REQ-024 Bench SHALL cover:
- ADDU 0x00221821, ihit=1 -> states 0,1,2,5,0; WB: reg_wen=1, reg_dst=0, alu_ctr=ALU_ADD; retired 0->1
- LW 0x8C220004, dhit low 3 cycles -> dren high 4 cycles; WB: mem_to_reg=1, reg_dst=1
- BEQ 0x10220003: zero=1 -> pc_wen=1, pc_src=1; zero=0 -> pc_wen=0; 3 cycles each
- JAL 0x0C000010 -> JUMP: pc_src=2, reg_wen=1, reg_dst=2
- ihit held 0, WAIT_W=4 -> after 15 FETCH cycles mem_timeout=1, state=8, halt=1 until n_rst
- n_rst asserted during MEMWR -> dwen=0 and state=0 with no clock edge; retired=0

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// wait timeout, sticky status flags and a retired-instruction counter.
module mc_control_unit #(
  parameter int WAIT_W     = 4,
  parameter int TIMEOUT_EN = 1,
  parameter int RETIRE_W   = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [31:0]         instr,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                zero,
  output logic                iren,
  output logic                dren,
  output logic                dwen,
  output logic                ir_wen,
  output logic                pc_wen,
  output logic                reg_wen,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_dst,
  output logic                alu_src,
  output logic [3:0]          alu_ctr,
  output logic                ext_op,
  output logic                upper,
  output logic                mem_to_reg,
  output logic [15:0]         imm16,
  output logic [3:0]          state,
  output logic                halt,
  output logic                mem_timeout,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC = 4'd2, MEMRD = 4'd3, MEMWR = 4'd4,
    WB = 4'd5, BRANCH = 4'd6, JUMP = 4'd7, HALT = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                         FN_SLTU = 6'h2B;
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd10, ALU_SLTU = 4'd11;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_t              r_state;
  logic                r_iren, r_dren, r_dwen, r_regWen, r_jumpPcWen;
  logic [1:0]          r_pcSrc, r_regDst;
  logic                r_aluSrc, r_extOp, r_upper, r_memToReg;
  logic [3:0]          r_aluCtr;
  logic [15:0]         r_imm16;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_halt, r_memTimeout, r_illegal;
  logic [RETIRE_W-1:0] r_retired;

  logic [5:0] w_op, w_funct;
  state_t     w_decNext, w_next;
  logic       w_illegal, w_aluSrc, w_extOp, w_upper, w_retire;
  logic [3:0] w_aluCtr;
  logic [1:0] w_regDst, w_pcSrc;
  logic [15:0] w_imm16;
  logic       w_fetchHit, w_waiting, w_timeout;

  assign w_op       = instr[31:26];
  assign w_funct    = instr[5:0];
  assign w_fetchHit = (r_state == FETCH) && r_iren && ihit;
  assign w_waiting  = ((r_state == FETCH) && r_iren && !ihit) ||
                      ((r_state == MEMRD || r_state == MEMWR) && !dhit);
  assign w_timeout  = (TIMEOUT_EN != 0) && w_waiting && (r_wait == WAIT_LAST);

  // Instruction decode: routing out of DECODE plus the datapath selects for the instruction.
  always_comb begin
    w_decNext = FETCH;
    w_illegal = 1'b0;
    w_aluCtr  = ALU_ADD;
    w_aluSrc  = 1'b1;
    w_extOp   = 1'b0;
    w_upper   = 1'b0;
    w_imm16   = instr[15:0];
    w_regDst  = 2'd1;
    w_pcSrc   = 2'd0;
    case (w_op)
      OP_RTYPE: begin
        w_regDst  = 2'd0;
        w_aluSrc  = 1'b0;
        w_decNext = EXEC;
        case (w_funct)
          FN_SLL:          begin w_aluCtr = ALU_SLL; w_aluSrc = 1'b1; w_imm16 = {11'b0, instr[10:6]}; end
          FN_SRL:          begin w_aluCtr = ALU_SRL; w_aluSrc = 1'b1; w_imm16 = {11'b0, instr[10:6]}; end
          FN_JR:           begin w_decNext = JUMP; w_pcSrc = 2'd3; end
          FN_ADD, FN_ADDU: w_aluCtr = ALU_ADD;
          FN_SUB, FN_SUBU: w_aluCtr = ALU_SUB;
          FN_AND:          w_aluCtr = ALU_AND;
          FN_OR:           w_aluCtr = ALU_OR;
          FN_XOR:          w_aluCtr = ALU_XOR;
          FN_NOR:          w_aluCtr = ALU_NOR;
          FN_SLT:          w_aluCtr = ALU_SLT;
          FN_SLTU:         w_aluCtr = ALU_SLTU;
          default:         begin w_decNext = FETCH; w_illegal = 1'b1; end
        endcase
      end
      OP_J:              begin w_decNext = JUMP; w_pcSrc = 2'd2; end
      OP_JAL:            begin w_decNext = JUMP; w_pcSrc = 2'd2; w_regDst = 2'd2; end
      OP_BEQ, OP_BNE:    begin w_decNext = BRANCH; w_aluCtr = ALU_SUB; w_aluSrc = 1'b0;
                               w_extOp = 1'b1; w_pcSrc = 2'd1; end
      OP_HALT:           w_decNext = HALT;
      OP_ADDI, OP_ADDIU: begin w_decNext = EXEC; w_extOp = 1'b1; end
      OP_SLTI:           begin w_decNext = EXEC; w_extOp = 1'b1; w_aluCtr = ALU_SLT; end
      OP_SLTIU:          begin w_decNext = EXEC; w_extOp = 1'b1; w_aluCtr = ALU_SLTU; end
      OP_ANDI:           begin w_decNext = EXEC; w_aluCtr = ALU_AND; end
      OP_ORI:            begin w_decNext = EXEC; w_aluCtr = ALU_OR; end
      OP_XORI:           begin w_decNext = EXEC; w_aluCtr = ALU_XOR; end
      OP_LUI:            begin w_decNext = EXEC; w_upper = 1'b1; end
      OP_LW, OP_SW:      begin w_decNext = EXEC; w_extOp = 1'b1; end
      default:           w_illegal = 1'b1;
    endcase
  end

  // A hit is tested before the timeout, so a hit on the terminal-count cycle still proceeds.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      FETCH:  if (w_fetchHit) w_next = DECODE; else if (w_timeout) w_next = HALT;
      DECODE: w_next = w_decNext;
      EXEC:   w_next = (w_op == OP_LW) ? MEMRD : (w_op == OP_SW) ? MEMWR : WB;
      MEMRD:  if (dhit) w_next = WB; else if (w_timeout) w_next = HALT;
      MEMWR:  if (dhit) begin w_next = FETCH; w_retire = 1'b1; end
              else if (w_timeout) w_next = HALT;
      WB, BRANCH, JUMP: begin w_next = FETCH; w_retire = 1'b1; end
      HALT:   w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  // Strobes are registered from the next state; selects are captured when DECODE
  // resolves and held until the instruction finishes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= FETCH;
      r_iren       <= 1'b0;
      r_dren       <= 1'b0;
      r_dwen       <= 1'b0;
      r_regWen     <= 1'b0;
      r_jumpPcWen  <= 1'b0;
      r_pcSrc      <= 2'd0;
      r_regDst     <= 2'd0;
      r_aluSrc     <= 1'b0;
      r_extOp      <= 1'b0;
      r_upper      <= 1'b0;
      r_memToReg   <= 1'b0;
      r_aluCtr     <= 4'd0;
      r_imm16      <= 16'd0;
      r_wait       <= '0;
      r_halt       <= 1'b0;
      r_memTimeout <= 1'b0;
      r_illegal    <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state     <= w_next;
      r_iren      <= (w_next == FETCH);
      r_dren      <= (w_next == MEMRD);
      r_dwen      <= (w_next == MEMWR);
      r_regWen    <= (w_next == WB) || ((w_next == JUMP) && (w_op == OP_JAL));
      r_jumpPcWen <= (w_next == JUMP);
      if ((w_next != r_state) && (w_next == FETCH || w_next == MEMRD || w_next == MEMWR))
        r_wait <= '0;
      else if (w_waiting && (r_wait != '1))
        r_wait <= r_wait + WAIT_ONE;
      if (w_next == FETCH || w_next == HALT) begin
        r_pcSrc    <= 2'd0;
        r_regDst   <= 2'd0;
        r_aluSrc   <= 1'b0;
        r_extOp    <= 1'b0;
        r_upper    <= 1'b0;
        r_memToReg <= 1'b0;
        r_aluCtr   <= 4'd0;
        r_imm16    <= 16'd0;
      end else if (r_state == DECODE) begin
        r_pcSrc    <= w_pcSrc;
        r_regDst   <= w_regDst;
        r_aluSrc   <= w_aluSrc;
        r_extOp    <= w_extOp;
        r_upper    <= w_upper;
        r_memToReg <= (w_op == OP_LW);
        r_aluCtr   <= w_aluCtr;
        r_imm16    <= w_imm16;
      end
      r_halt       <= r_halt | (w_next == HALT);
      r_memTimeout <= r_memTimeout | w_timeout;
      r_illegal    <= r_illegal | ((r_state == DECODE) && w_illegal);
      if (w_retire)
        r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign iren        = r_iren;
  assign dren        = r_dren;
  assign dwen        = r_dwen;
  assign ir_wen      = w_fetchHit;
  assign pc_wen      = w_fetchHit | r_jumpPcWen |
                       ((r_state == BRANCH) && (zero ^ (w_op == OP_BNE)));
  assign reg_wen     = r_regWen;
  assign pc_src      = r_pcSrc;
  assign reg_dst     = r_regDst;
  assign alu_src     = r_aluSrc;
  assign alu_ctr     = r_aluCtr;
  assign ext_op      = r_extOp;
  assign upper       = r_upper;
  assign mem_to_reg  = r_memToReg;
  assign imm16       = r_imm16;
  assign state       = r_state;
  assign halt        = r_halt;
  assign mem_timeout = r_memTimeout;
  assign illegal_op  = r_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a per-cycle vector table for a short program,
// then hand-written reset, timeout and hit-priority sequences.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] instr;
  logic        ihit, dhit, zero;
  logic        iren, dren, dwen, ir_wen, pc_wen, reg_wen;
  logic [1:0]  pc_src, reg_dst;
  logic        alu_src, ext_op, upper, mem_to_reg;
  logic [3:0]  alu_ctr, state;
  logic [15:0] imm16;
  logic        halt, mem_timeout, illegal_op;
  logic [15:0] retired;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] I_ADDU = 32'h00221821, I_LW = 32'h8C220004, I_BEQ = 32'h10220003,
                          I_JAL = 32'h0C000010, I_JR = 32'h03E00008, I_LBU = 32'h90000000,
                          I_SW = 32'hAC220008;

  typedef struct {
    logic [31:0] instr;
    logic        ihit, dhit, zero;
    logic [3:0]  st;
    logic        iren, dren, dwen, irWen, pcWen, regWen;
    logic [1:0]  pcSrc, regDst;
    logic [3:0]  alu;
    logic        m2r;
    logic [15:0] ret;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs[NVEC];

  mc_control_unit #(.WAIT_W(4), .TIMEOUT_EN(1), .RETIRE_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
    .iren(iren), .dren(dren), .dwen(dwen), .ir_wen(ir_wen), .pc_wen(pc_wen),
    .reg_wen(reg_wen), .pc_src(pc_src), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_ctr(alu_ctr), .ext_op(ext_op), .upper(upper), .mem_to_reg(mem_to_reg),
    .imm16(imm16), .state(state), .halt(halt), .mem_timeout(mem_timeout),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] in, input logic ih, input logic dh, input logic z,
                              input logic [3:0] st, input logic ir, input logic dr, input logic dw,
                              input logic irw, input logic pcw, input logic rw,
                              input logic [1:0] ps, input logic [1:0] rd, input logic [3:0] alu,
                              input logic m2r, input logic [15:0] ret);
    vec_t v;
    v.instr = in; v.ihit = ih; v.dhit = dh; v.zero = z;
    v.st = st; v.iren = ir; v.dren = dr; v.dwen = dw;
    v.irWen = irw; v.pcWen = pcw; v.regWen = rw;
    v.pcSrc = ps; v.regDst = rd; v.alu = alu; v.m2r = m2r; v.ret = ret;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    instr = v.instr;
    ihit  = v.ihit;
    dhit  = v.dhit;
    zero  = v.zero;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.state", i),      state,      v.st);
    checkOutput($sformatf("v%0d.iren", i),       iren,       v.iren);
    checkOutput($sformatf("v%0d.dren", i),       dren,       v.dren);
    checkOutput($sformatf("v%0d.dwen", i),       dwen,       v.dwen);
    checkOutput($sformatf("v%0d.ir_wen", i),     ir_wen,     v.irWen);
    checkOutput($sformatf("v%0d.pc_wen", i),     pc_wen,     v.pcWen);
    checkOutput($sformatf("v%0d.reg_wen", i),    reg_wen,    v.regWen);
    checkOutput($sformatf("v%0d.pc_src", i),     pc_src,     v.pcSrc);
    checkOutput($sformatf("v%0d.reg_dst", i),    reg_dst,    v.regDst);
    checkOutput($sformatf("v%0d.alu_ctr", i),    alu_ctr,    v.alu);
    checkOutput($sformatf("v%0d.mem_to_reg", i), mem_to_reg, v.m2r);
    checkOutput($sformatf("v%0d.retired", i),    retired,    v.ret);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // instr ihit dhit zero | state iren dren dwen ir_wen pc_wen reg_wen pc_src reg_dst alu m2r retired
    vecs[0]  = mk(I_ADDU, 1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(I_ADDU, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(I_ADDU, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    vecs[3]  = mk(I_ADDU, 1, 0, 0,  5, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0);
    vecs[4]  = mk(I_LW,   1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(I_LW,   1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(I_LW,   1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[7]  = mk(I_LW,   1, 0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[8]  = mk(I_LW,   1, 0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[9]  = mk(I_LW,   1, 0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[10] = mk(I_LW,   1, 1, 0,  3, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1);
    vecs[11] = mk(I_LW,   1, 0, 0,  5, 0, 0, 0, 0, 0, 1, 0, 1, 2, 1, 1);
    vecs[12] = mk(I_BEQ,  1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2);
    vecs[13] = mk(I_BEQ,  1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    vecs[14] = mk(I_BEQ,  1, 0, 1,  6, 0, 0, 0, 0, 1, 0, 1, 1, 3, 0, 2);
    vecs[15] = mk(I_BEQ,  1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3);
    vecs[16] = mk(I_BEQ,  1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    vecs[17] = mk(I_BEQ,  1, 0, 0,  6, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 3);
    vecs[18] = mk(I_JAL,  1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4);
    vecs[19] = mk(I_JAL,  1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    vecs[20] = mk(I_JAL,  1, 0, 0,  7, 0, 0, 0, 0, 1, 1, 2, 2, 2, 0, 4);
    vecs[21] = mk(I_JR,   1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5);
    vecs[22] = mk(I_JR,   1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    vecs[23] = mk(I_JR,   1, 0, 0,  7, 0, 0, 0, 0, 1, 0, 3, 0, 2, 0, 5);
    vecs[24] = mk(I_LBU,  1, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6);
    vecs[25] = mk(I_LBU,  1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    vecs[26] = mk(I_LBU,  0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);

    n_rst = 1'b0;
    instr = 32'd0;
    ihit  = 1'b0;
    dhit  = 1'b0;
    zero  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.state", state, 4'd0);
    checkOutput("rst.iren", iren, 1'b0);
    checkOutput("rst.retired", retired, 16'd0);
    n_rst = 1'b1;
    #1;
    checkOutput("rel.iren_before_edge", iren, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      nextCycle();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
    end
    checkOutput("illegal_op_sticky", illegal_op, 1'b1);
    checkOutput("no_halt_yet", halt, 1'b0);

    // Store that is reset while it waits on the data memory.
    nextCycle(); instr = I_SW; ihit = 1'b1; dhit = 1'b0;
    nextCycle(); ihit = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("sw.state_memwr", state, 4'd4);
    checkOutput("sw.dwen", dwen, 1'b1);
    checkOutput("sw.dren", dren, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("sw.dwen_held", dwen, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("sw_rst.dwen", dwen, 1'b0);
    checkOutput("sw_rst.state", state, 4'd0);
    checkOutput("sw_rst.retired", retired, 16'd0);
    checkOutput("sw_rst.illegal_op", illegal_op, 1'b0);
    checkOutput("sw_rst.iren", iren, 1'b0);

    // Instruction memory never answers: 15 waiting FETCH cycles then halt.
    @(negedge clk);
    instr = I_ADDU; ihit = 1'b0; dhit = 1'b0;
    n_rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      nextCycle();
      @(negedge clk);
      if (k == 1) checkOutput("to.iren_first", iren, 1'b1);
    end
    checkOutput("to.state_c15", state, 4'd0);
    checkOutput("to.no_timeout_c15", mem_timeout, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("to.state_halt", state, 4'd8);
    checkOutput("to.mem_timeout", mem_timeout, 1'b1);
    checkOutput("to.halt", halt, 1'b1);
    checkOutput("to.iren_off", iren, 1'b0);
    ihit = 1'b1;
    repeat (3) begin
      nextCycle();
      @(negedge clk);
    end
    checkOutput("to.state_stays", state, 4'd8);
    checkOutput("to.halt_sticky", halt, 1'b1);
    checkOutput("to.pc_wen_off", pc_wen, 1'b0);
    checkOutput("to.iren_stays_off", iren, 1'b0);
    n_rst = 1'b0;
    #1;
    checkOutput("to_rst.halt", halt, 1'b0);
    checkOutput("to_rst.mem_timeout", mem_timeout, 1'b0);

    // Hit on the terminal-count cycle wins over the timeout.
    @(negedge clk);
    ihit = 1'b0;
    n_rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      nextCycle();
    end
    nextCycle();
    ihit = 1'b1;
    @(negedge clk);
    checkOutput("hp.ir_wen", ir_wen, 1'b1);
    checkOutput("hp.state_fetch", state, 4'd0);
    nextCycle();
    ihit = 1'b0;
    @(negedge clk);
    checkOutput("hp.state_decode", state, 4'd1);
    checkOutput("hp.no_timeout", mem_timeout, 1'b0);
    checkOutput("hp.no_halt", halt, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
